tx_frame_ctrl: RTL
==================

# tx_frame_ctrl

Transmit-side frame scheduler that sequences the bit stream fed to the convolutional encoder/interleaver/modulator chain. Arbitrates between two byte-wide sources (UART and sampling front-end) at frame boundaries and wraps each frame in preamble, sync word and header. Appends zero tail bits to flush the encoder and inserts an idle gap between frames. Drives `data_send`/`valid_send`, paced by a one-cycle `bit_en` strobe from the slow-clock domain logic.

## Interface
Parameters:
- `PAYLOAD_BYTES`, 4: payload bytes per frame (1–16).
- `TAIL_BITS`, 2: zero bits after the last data bit (encoder memory flush).
- `GAP_BITS`, 4: idle bit slots between frames, with `valid_send` low.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `bit_en` in 1: one-cycle strobe; one output bit slot per pulse.
- `src0_valid` in 1: UART source has a byte / requests a frame.
- `src0_data` in 8: UART byte.
- `src0_ready` out 1: byte taken this cycle.
- `src1_valid`, `src1_data`, `src1_ready`: same as above, for the sampling source.
- `data_send` out 1: serial bit to the encoder.
- `valid_send` out 1: high for every frame bit slot.
- `grant` out 2: one-hot owner of the current frame; 0 when idle.
- `busy` out 1: high from frame start until the gap ends.
- `frame_done` out 1: one-cycle pulse when the last tail bit is issued.
- `underrun` out 1: one-cycle pulse when a payload byte is padded.

## Operation
- States: IDLE → PRE → SYNC → HDR → PAY → (CRC) → TAIL → GAP → IDLE.
- IDLE: on `bit_en` with any `srcN_valid` high:
  - Round-robin pick: the source not granted last wins when both are requesting.
  - After reset, src0 has priority.
  - Emit the first PRE bit in the same step. `grant` is held until GAP exits.
- PRE: 8 bits 0xAA. SYNC: 8 bits 0x2D. HDR: 8 bits = {src id, seq[6:0]}. All fields MSB first.
- PAY: `PAYLOAD_BYTES` bytes. On the `bit_en` that begins each byte:
  - If the granted source's valid is high: `srcN_ready`=1 combinationally for that cycle, and the byte is loaded into the shift register and its MSB emitted.
  - If valid is low: emit 0x00 for that byte and pulse `underrun`.
- The ungranted source's ready stays 0 throughout the frame.
- TAIL: `TAIL_BITS` zeros; `frame_done` pulses on the last tail bit. `seq` increments, wrapping 127→0.
- GAP: `GAP_BITS` slots with `valid_send`=0, `data_send`=0. Then IDLE with `busy`=0 and `grant`=0.
- Frame length in bit slots: 24 + 8·PAYLOAD_BYTES (+8 with CRC) + TAIL_BITS.

## Timing
- All outputs are registered except `srcN_ready`.
- Each bit appears on `data_send`/`valid_send` the cycle after its `bit_en` and holds until the next bit.
- Cycles without `bit_en` never change state or outputs. Pulse outputs last exactly one cycle.
- Frame start latency: first preamble bit appears 1 cycle after the `bit_en` that sampled the request.
- Reset (`reset`=0 at a posedge) has priority over `bit_en`. Post-reset values:
  - All outputs 0, state IDLE, `seq`=0, round-robin pointer = src1, so src0 wins first.
- Reset mid-frame aborts immediately:
  - `valid_send`=0 the next cycle.
  - No `frame_done`; `seq` is not incremented.
- A source's valid dropping during HDR/PRE has no effect; only byte-start sampling matters.
- `bit_en` on consecutive cycles is legal.

## Configuration
- `TX_FRAME_CRC_EN` defined:
  - CRC state inserted between PAY and TAIL.
  - Emits CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over HDR+PAY bits, MSB first.
- `TX_FRAME_CRC_EN` undefined: PAY goes directly to TAIL and no CRC logic is present.

## Structure
- `tx_frame_pkg` holds:
  - The state enum.
  - `PREAMBLE`=8'hAA, `SYNC_WORD`=8'h2D, `CRC_POLY`=8'h07, field width constants.
- Sub-module `crc8_serial`: bit-serial CRC with `clk`, `reset`, `clr`, `en`, `din`, `crc[7:0]`. Instantiated only under `TX_FRAME_CRC_EN`.

## Test plan
- Basic frame, PAYLOAD_BYTES=2, src0 bytes 0x96, 0x0F ready, `bit_en` every 8 cycles:
  - Serial stream is AA 2D 00 96 0F then 00b tail.
  - `frame_done` is pulsed once.
  - `src0_ready` is pulsed twice.
- Both sources request continuously: grants alternate src0, src1, src0; headers 0x00, 0x81, 0x02.
- src0 valid drops before the second payload byte:
  - Byte 2 is sent as 0x00.
  - `underrun` pulses exactly once; the frame still completes.
- Reset asserted during PAY byte 1:
  - Next cycle all outputs are 0.
  - Next frame header shows seq=0 and is granted to src0.
- With `TX_FRAME_CRC_EN`, payload 0x96 0x0F, header 0x00: CRC byte matches a reference CRC-8/0x07 over 00 96 0F. Without the macro, the frame is 8 bits shorter.
- Gap check: after `frame_done`, exactly `GAP_BITS`=4 `bit_en` slots pass with `valid_send`=0 before the next preamble, even with a request pending.

Source files
------------

// File: rtl/tx_frame_pkg.sv
// tx_frame_pkg: shared state encoding, framing constants and CRC-8 step
// for the transmit frame scheduler.
package tx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SYNC,
        ST_HDR,
        ST_PAY,
        ST_CRC,
        ST_TAIL,
        ST_GAP
    } tx_state_t;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned SEQ_W     = 7;
    localparam logic [7:0]  PREAMBLE  = 8'hAA;
    localparam logic [7:0]  SYNC_WORD = 8'h2D;
    localparam logic [7:0]  CRC_POLY  = 8'h07;

    // One MSB-first CRC-8 step: shift in a single data bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 (poly 0x07, init 0x00), one bit per en.
module crc8_serial
    import tx_frame_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    // Accumulate one bit per enable; clr restarts the checksum for a new frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: round-robin frame scheduler feeding the encoder chain.
// Frame: preamble, sync, header {src id, seq}, payload, [CRC], tail, gap.
// Optional feature macro: TX_FRAME_CRC_EN appends CRC-8 over header+payload.
module tx_frame_ctrl
    import tx_frame_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter int unsigned TAIL_BITS     = 2,
    parameter int unsigned GAP_BITS      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       src0_valid,
    input  logic [7:0] src0_data,
    output logic       src0_ready,
    input  logic       src1_valid,
    input  logic [7:0] src1_data,
    output logic       src1_ready,
    output logic       data_send,
    output logic       valid_send,
    output logic [1:0] grant,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [3:0] PAY_LAST = 4'(PAYLOAD_BYTES - 1);
    localparam logic [7:0] TAIL_N   = 8'(TAIL_BITS);
    localparam logic [7:0] GAP_N    = 8'(GAP_BITS);

    tx_state_t  state;
    tx_state_t  load_state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [3:0] byte_cnt;
    logic [7:0] slot_cnt;
    logic [6:0] seq;
    logic       last_src;
    logic       req_any;
    logic       pick_src;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic [7:0] pay_byte;
    logic       load_en;
    logic       pay_start;
    logic       to_tail;
    logic [7:0] load_byte;

    assign req_any   = src0_valid | src1_valid;
    assign pick_src  = (src0_valid & src1_valid) ? ~last_src : src1_valid;
    assign sel_valid = grant[1] ? src1_valid : src0_valid;
    assign sel_data  = grant[1] ? src1_data : src0_data;
    assign pay_byte  = sel_valid ? sel_data : 8'h00;

    assign src0_ready = reset & pay_start & grant[0] & src0_valid;
    assign src1_ready = reset & pay_start & grant[1] & src1_valid;

`ifdef TX_FRAME_CRC_EN
    logic [7:0] crc_val;
    logic       crc_clr;
    logic       crc_feed;
    logic       tx_bit;

    assign tx_bit   = load_en ? load_byte[7] : shreg[7];
    assign crc_clr  = bit_en & (state == ST_IDLE) & req_any;
    assign crc_feed = bit_en & ((load_en & (load_state == ST_HDR || load_state == ST_PAY)) |
                                (!load_en & (state == ST_HDR || state == ST_PAY)));

    crc8_serial u_crc (
        .clk   (clk),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_feed),
        .din   (tx_bit),
        .crc   (crc_val)
    );
`endif

    // Byte-boundary decode: which byte is loaded next, or whether the tail starts.
    always_comb begin
        load_en    = 1'b0;
        pay_start  = 1'b0;
        to_tail    = 1'b0;
        load_byte  = '0;
        load_state = state;
        if (bit_en && bit_cnt == 3'd0) begin
            case (state)
                ST_PRE: begin
                    load_en    = 1'b1;
                    load_byte  = SYNC_WORD;
                    load_state = ST_SYNC;
                end
                ST_SYNC: begin
                    load_en    = 1'b1;
                    load_byte  = {grant[1], seq};
                    load_state = ST_HDR;
                end
                ST_HDR: begin
                    pay_start  = 1'b1;
                    load_en    = 1'b1;
                    load_byte  = pay_byte;
                    load_state = ST_PAY;
                end
                ST_PAY: begin
                    if (byte_cnt != PAY_LAST) begin
                        pay_start  = 1'b1;
                        load_en    = 1'b1;
                        load_byte  = pay_byte;
                        load_state = ST_PAY;
                    end else begin
`ifdef TX_FRAME_CRC_EN
                        load_en    = 1'b1;
                        load_byte  = crc_val;
                        load_state = ST_CRC;
`else
                        to_tail    = 1'b1;
`endif
                    end
                end
                ST_CRC:  to_tail = 1'b1;
                default: ;
            endcase
        end
    end

    // Frame sequencer: every register advances only on bit_en; pulses self-clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            slot_cnt   <= '0;
            seq        <= '0;
            last_src   <= 1'b1;
            grant      <= '0;
            busy       <= 1'b0;
            data_send  <= 1'b0;
            valid_send <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            if (bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (req_any) begin
                            grant      <= pick_src ? 2'b10 : 2'b01;
                            last_src   <= pick_src;
                            busy       <= 1'b1;
                            valid_send <= 1'b1;
                            data_send  <= PREAMBLE[7];
                            shreg      <= {PREAMBLE[6:0], 1'b0};
                            bit_cnt    <= 3'd1;
                            state      <= ST_PRE;
                        end
                    end
                    ST_PRE, ST_SYNC, ST_HDR, ST_PAY, ST_CRC: begin
                        if (load_en) begin
                            data_send <= load_byte[7];
                            shreg     <= {load_byte[6:0], 1'b0};
                            bit_cnt   <= 3'd1;
                            state     <= load_state;
                            if (pay_start) begin
                                byte_cnt <= (state == ST_HDR) ? 4'd0 : byte_cnt + 4'd1;
                                if (!sel_valid) underrun <= 1'b1;
                            end
                        end else if (to_tail) begin
                            data_send <= 1'b0;
                            slot_cnt  <= 8'd1;
                            state     <= ST_TAIL;
                            if (TAIL_N == 8'd1) begin
                                frame_done <= 1'b1;
                                seq        <= seq + 7'd1;
                            end
                        end else begin
                            data_send <= shreg[7];
                            shreg     <= {shreg[6:0], 1'b0};
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                    ST_TAIL: begin
                        data_send <= 1'b0;
                        if (slot_cnt == TAIL_N) begin
                            // First gap slot is consumed here so the gap spans exactly GAP_BITS slots.
                            valid_send <= 1'b0;
                            slot_cnt   <= 8'd1;
                            if (GAP_N <= 8'd1) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                grant <= '0;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            slot_cnt <= slot_cnt + 8'd1;
                            if (slot_cnt + 8'd1 == TAIL_N) begin
                                frame_done <= 1'b1;
                                seq        <= seq + 7'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (slot_cnt + 8'd1 == GAP_N) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            grant <= '0;
                        end else begin
                            slot_cnt <= slot_cnt + 8'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
